// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: a DEPTH-entry circular buffer of
// IF/ID records, with a synchronous flush on redirect and a PC stall request while full.

package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid_if_id;
  } if_id_reg_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq_valid,
  input  if_id_reg_t                   enq_data,
  output logic                         enq_ready,
  output logic                         deq_valid,
  output if_id_reg_t                   deq_data,
  input  logic                         deq_ready,
  input  logic                         flush,
  output logic                         pc_stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  if_id_reg_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_full;
  logic          not_empty;
  logic          enq_fire;
  logic          deq_fire;
  logic          wr_en;

  assign not_full  = (count != FULL);
  assign not_empty = (count != '0);

  // Held at 1 while in reset so the hazard unit never sees a stall from an idle queue.
  assign enq_ready    = ~reset | (not_full & ~flush);
  assign deq_valid    = reset & not_empty & ~flush;
  assign pc_stall_req = ~enq_ready;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;
  // Bubbles from fetch are accepted (handshake completes) but never stored.
  assign wr_en    = enq_fire & enq_data.valid_if_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are masked by deq_valid below.
  always_ff @(posedge clk) begin
    if (wr_en && reset && !flush) mem[wr_ptr] <= enq_data;
  end

  always_comb begin
    deq_data = '0;
    if (deq_valid) begin
      deq_data             = mem[rd_ptr];
      deq_data.valid_if_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based reference model.

module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enq_valid = 1'b0;
  logic       deq_ready = 1'b0;
  logic       flush = 1'b0;
  if_id_reg_t enq_data = '0;
  if_id_reg_t deq_data;
  logic       enq_ready;
  logic       deq_valid;
  logic       pc_stall_req;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        v;
    logic        dr;
    logic        fl;
    logic [2:0]  cnt;
    logic        dv;
    logic [31:0] hpc;
  } vec_t;

  vec_t vecs[12];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .deq_ready    (deq_ready),
    .flush        (flush),
    .pc_stall_req (pc_stall_req),
    .count        (count)
  );

  always #5 clk = ~clk;

  function automatic if_id_reg_t mk(input logic [31:0] pc, input logic v);
    if_id_reg_t e;
    e.pc          = pc;
    e.instruction = pc ^ 32'h1357_9bdf;
    e.pc_plus4    = pc + 32'd4;
    e.valid_if_id = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic v,
                       input logic dr, input logic fl);
    enq_valid = ev;
    enq_data  = mk(pc, v);
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("rst_deq_data", 128'(deq_data), 128'(0));
    chk("rst_enq_ready", 128'(enq_ready), 128'(1));
    chk("rst_pc_stall", 128'(pc_stall_req), 128'(0));
    #2;
    rst_n = 1'b1;
  endtask

  task automatic enq_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
  endtask

  initial begin
    if_id_reg_t q[$];
    if_id_reg_t exp_d;
    logic       e_rdy, e_dv, ev, dr, fl, v;
    logic [31:0] pc;

    vecs[0]  = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 32'h00};
    vecs[1]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 32'h00};
    vecs[2]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 32'h00};
    vecs[4]  = '{1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 32'h04};
    vecs[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h04};
    vecs[6]  = '{1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 32'h08};
    vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 32'h0C};
    vecs[8]  = '{1'b1, 32'h1C, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 32'h00};
    vecs[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h00};
    vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h00};
    vecs[11] = '{1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 32'h24};

    // Directed vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ev, vecs[i].pc, vecs[i].v, vecs[i].dr, vecs[i].fl);
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].cnt));
      chk($sformatf("vec%0d_deq_valid", i), 128'(deq_valid), 128'(vecs[i].dv));
      chk($sformatf("vec%0d_head_pc", i), 128'(deq_data.pc), 128'(vecs[i].hpc));
    end

    // Fill then drain in order
    do_reset();
    enq_n(4, 32'h0);
    #1;
    chk("fill_count", 128'(count), 128'(4));
    chk("fill_enq_ready", 128'(enq_ready), 128'(0));
    chk("fill_pc_stall", 128'(pc_stall_req), 128'(1));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      chk($sformatf("drain%0d_valid", i), 128'(deq_valid), 128'(1));
      chk($sformatf("drain%0d_pc", i), 128'(deq_data.pc), 128'(4 * i));
      tick();
    end
    idle();
    #1;
    chk("drain_empty_valid", 128'(deq_valid), 128'(0));

    // Streaming at count 2 across pointer wrap
    do_reset();
    enq_n(2, 32'h40);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h48 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
      #1;
      chk($sformatf("stream%0d_data", i), 128'(deq_data),
          128'(mk(32'h40 + 32'(4 * i), 1'b1)));
      tick();
      chk($sformatf("stream%0d_count", i), 128'(count), 128'(2));
    end
    idle();

    // Flush with enqueue and dequeue requested in the same cycle
    do_reset();
    enq_n(3, 32'h80);
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    #1;
    chk("flush_deq_valid", 128'(deq_valid), 128'(0));
    chk("flush_enq_ready", 128'(enq_ready), 128'(0));
    tick();
    idle();
    #1;
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_deq_data", 128'(deq_data), 128'(0));

    // Asynchronous reset mid-operation
    do_reset();
    enq_n(2, 32'hC0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("async_rst_count", 128'(count), 128'(0));
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("post_rst_valid", 128'(deq_valid), 128'(1));
    chk("post_rst_pc", 128'(deq_data.pc), 128'(32'h100));

    // Randomized traffic vs. queue model
    do_reset();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      ev = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 1) != 0);
      fl = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 7) != 0);
      pc = $urandom() & 32'hFFFF_FFFC;
      drive(ev, pc, v, dr, fl);
      #1;
      e_rdy = (q.size() != DEPTH) && !fl;
      e_dv  = (q.size() != 0) && !fl;
      exp_d = e_dv ? q[0] : '0;
      chk("rnd_enq_ready", 128'(enq_ready), 128'(e_rdy));
      chk("rnd_deq_valid", 128'(deq_valid), 128'(e_dv));
      chk("rnd_deq_data", 128'(deq_data), 128'(exp_d));
      chk("rnd_count", 128'(count), 128'(q.size()));
      chk("rnd_pc_stall", 128'(pc_stall_req), 128'(!e_rdy));
      if (fl) begin
        q.delete();
      end else begin
        if (e_dv && dr) void'(q.pop_front());
        if (e_rdy && ev && v) q.push_back(mk(pc, 1'b1));
      end
      tick();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
